// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with an overflow-trap FSM and a saturating trap counter.
// Trap-eligible overflows squash the instruction and hold exc_req until exc_ack.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   RUN   | normal pipelining; ex_* captured into mem_* when accepted
//   TRAP  | exception pending; input ignored, exc_req high until exc_ack
module ex_mem_reg #(
  parameter int EXC_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic [31:0]          ex_pc,
  input  logic [31:0]          ex_alu_out,
  input  logic                 ex_zero,
  input  logic                 ex_great,
  input  logic                 ex_overflow,
  input  logic                 ex_trap_en,
  input  logic [31:0]          ex_store_data,
  input  logic [4:0]           ex_dst,
  input  logic                 ex_reg_write,
  input  logic                 ex_mem_read,
  input  logic                 ex_mem_write,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 exc_ack,
  output logic                 ex_ready,
  output logic                 mem_valid,
  output logic [31:0]          mem_pc,
  output logic [31:0]          mem_alu_out,
  output logic                 mem_zero,
  output logic                 mem_great,
  output logic [31:0]          mem_store_data,
  output logic [4:0]           mem_dst,
  output logic                 mem_reg_write,
  output logic                 mem_mem_read,
  output logic                 mem_mem_write,
  output logic                 exc_req,
  output logic [31:0]          exc_epc,
  output logic [EXC_CNT_W-1:0] trap_cnt
);

  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

  localparam logic [EXC_CNT_W-1:0] CNT_MAX = {EXC_CNT_W{1'b1}};

  state_t state_q, state_d;
  logic   accept;
  logic   trap_hit;

  assign accept   = ex_ready & ex_valid & ~flush;
  assign trap_hit = ex_trap_en & ex_overflow;

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:  if (accept && trap_hit) state_d = TRAP;
      TRAP: if (exc_ack) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    ex_ready = (state_q == RUN) & ~stall;
    exc_req  = (state_q == TRAP);
  end

  // Control bits are cleared on every entry to TRAP, so TRAP only needs to hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid      <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_pc         <= 32'h0;
      mem_alu_out    <= 32'h0;
      mem_zero       <= 1'b0;
      mem_great      <= 1'b0;
      mem_store_data <= 32'h0;
      mem_dst        <= 5'd0;
      exc_epc        <= 32'h0;
      trap_cnt       <= '0;
    end else if (state_q == RUN) begin
      if (flush || (!stall && (!ex_valid || trap_hit))) begin
        mem_valid     <= 1'b0;
        mem_reg_write <= 1'b0;
        mem_mem_read  <= 1'b0;
        mem_mem_write <= 1'b0;
      end else if (!stall) begin
        mem_valid      <= 1'b1;
        mem_reg_write  <= ex_reg_write;
        mem_mem_read   <= ex_mem_read;
        mem_mem_write  <= ex_mem_write;
        mem_pc         <= ex_pc;
        mem_alu_out    <= ex_alu_out;
        mem_zero       <= ex_zero;
        mem_great      <= ex_great;
        mem_store_data <= ex_store_data;
        mem_dst        <= ex_dst;
      end
      if (accept && trap_hit) begin
        exc_epc <= ex_pc;
        if (trap_cnt != CNT_MAX) trap_cnt <= trap_cnt + EXC_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: a cycle model compared every cycle,
// plus literal expectations at key points of a directed sequence.
module tb_ex_mem_reg;

  localparam int W   = 2;
  localparam int MAX = (1 << W) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_zero, ex_great, ex_overflow, ex_trap_en;
  logic [31:0] ex_pc, ex_alu_out, ex_store_data;
  logic [4:0]  ex_dst;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic        stall, flush, exc_ack;
  logic        ex_ready, mem_valid, mem_zero, mem_great;
  logic [31:0] mem_pc, mem_alu_out, mem_store_data, exc_epc;
  logic [4:0]  mem_dst;
  logic        mem_reg_write, mem_mem_read, mem_mem_write, exc_req;
  logic [W-1:0] trap_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  ex_mem_reg #(.EXC_CNT_W(W)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_out(ex_alu_out),
    .ex_zero(ex_zero), .ex_great(ex_great), .ex_overflow(ex_overflow), .ex_trap_en(ex_trap_en),
    .ex_store_data(ex_store_data), .ex_dst(ex_dst), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .stall(stall), .flush(flush),
    .exc_ack(exc_ack), .ex_ready(ex_ready), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .mem_alu_out(mem_alu_out), .mem_zero(mem_zero), .mem_great(mem_great),
    .mem_store_data(mem_store_data), .mem_dst(mem_dst), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .exc_req(exc_req),
    .exc_epc(exc_epc), .trap_cnt(trap_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the pipeline register must hold after each edge.
  typedef struct {
    bit          valid, rw, mr, mw, zero, great;
    logic [31:0] pc, alu, sd, epc;
    logic [4:0]  dst;
  } slot_t;

  slot_t m;
  bit    m_trap;
  int    m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m = '{default: '0};
      m_trap = 1'b0;
      m_cnt = 0;
    end else if (m_trap) begin
      if (exc_ack) m_trap = 1'b0;
    end else if (flush) begin
      {m.valid, m.rw, m.mr, m.mw} = 4'b0;
    end else if (stall) begin
      // hold
    end else if (!ex_valid) begin
      {m.valid, m.rw, m.mr, m.mw} = 4'b0;
    end else if (ex_trap_en && ex_overflow) begin
      {m.valid, m.rw, m.mr, m.mw} = 4'b0;
      m.epc = ex_pc;
      m_trap = 1'b1;
      m_cnt = (m_cnt < MAX) ? m_cnt + 1 : MAX;
    end else begin
      m.valid = 1'b1;
      m.rw = ex_reg_write; m.mr = ex_mem_read; m.mw = ex_mem_write;
      m.pc = ex_pc; m.alu = ex_alu_out; m.zero = ex_zero; m.great = ex_great;
      m.sd = ex_store_data; m.dst = ex_dst;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("ex_ready", 32'(ex_ready), 32'(!m_trap && !stall));
      chk("exc_req", 32'(exc_req), 32'(m_trap));
      chk("exc_epc", exc_epc, m.epc);
      chk("trap_cnt", 32'(trap_cnt), 32'(m_cnt));
      chk("mem_valid", 32'(mem_valid), 32'(m.valid));
      chk("mem_ctrl", 32'({mem_reg_write, mem_mem_read, mem_mem_write}), 32'({m.rw, m.mr, m.mw}));
      if (m.valid) begin
        chk("mem_pc", mem_pc, m.pc);
        chk("mem_alu_out", mem_alu_out, m.alu);
        chk("mem_flags", 32'({mem_zero, mem_great}), 32'({m.zero, m.great}));
        chk("mem_store_data", mem_store_data, m.sd);
        chk("mem_dst", 32'(mem_dst), 32'(m.dst));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 0; ex_pc = 0; ex_alu_out = 0; ex_zero = 0; ex_great = 0;
    ex_overflow = 0; ex_trap_en = 0; ex_store_data = 0; ex_dst = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0;
    stall = 0; flush = 0; exc_ack = 0;
  endtask

  task automatic trap_instr(input logic [31:0] pc);
    idle();
    ex_valid = 1; ex_pc = pc; ex_alu_out = 32'h8000_0000;
    ex_overflow = 1; ex_trap_en = 1; ex_reg_write = 1; ex_dst = 5'd9;
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    checking = 1'b1;
    tick();
    chk("rst mem_valid", 32'(mem_valid), 32'h0);
    chk("rst exc_req", 32'(exc_req), 32'h0);
    chk("rst trap_cnt", 32'(trap_cnt), 32'h0);
    chk("rst mem_pc", mem_pc, 32'h0);
    chk("rst ex_ready", 32'(ex_ready), 32'h1);

    // pass-through
    rst = 0;
    ex_valid = 1; ex_pc = 32'h100; ex_alu_out = 32'h7; ex_dst = 5'd5; ex_reg_write = 1;
    tick();
    chk("pass mem_valid", 32'(mem_valid), 32'h1);
    chk("pass mem_alu_out", mem_alu_out, 32'h7);
    chk("pass mem_dst", 32'(mem_dst), 32'h5);
    chk("pass mem_reg_write", 32'(mem_reg_write), 32'h1);

    // overflow trap, flush while trapped, then ack with an instruction present
    trap_instr(32'h0040_0010);
    tick();
    idle();
    chk("trap exc_req", 32'(exc_req), 32'h1);
    chk("trap exc_epc", exc_epc, 32'h0040_0010);
    chk("trap mem_valid", 32'(mem_valid), 32'h0);
    chk("trap ex_ready", 32'(ex_ready), 32'h0);
    chk("trap trap_cnt", 32'(trap_cnt), 32'h1);
    flush = 1; ex_valid = 1; ex_alu_out = 32'h55;
    tick();
    chk("trap flush exc_req", 32'(exc_req), 32'h1);
    flush = 0; exc_ack = 1;
    tick();
    chk("ack exc_req", 32'(exc_req), 32'h0);
    chk("ack ex_ready", 32'(ex_ready), 32'h1);
    chk("ack no accept", 32'(mem_valid), 32'h0);

    // unsigned wrap passes through
    idle();
    ex_valid = 1; ex_pc = 32'h200; ex_overflow = 1; ex_trap_en = 0; ex_alu_out = 32'h0;
    ex_zero = 1; ex_reg_write = 1; ex_dst = 5'd3;
    tick();
    chk("wrap mem_valid", 32'(mem_valid), 32'h1);
    chk("wrap mem_alu_out", mem_alu_out, 32'h0);
    chk("wrap mem_zero", 32'(mem_zero), 32'h1);
    chk("wrap exc_req", 32'(exc_req), 32'h0);

    // stall holds, stall+flush kills
    idle();
    ex_valid = 1; ex_pc = 32'h300; ex_alu_out = 32'h1234; ex_great = 1;
    ex_store_data = 32'hCAFE_F00D; ex_mem_write = 1; ex_dst = 5'd0;
    tick();
    stall = 1; ex_alu_out = 32'hDEAD; ex_mem_write = 0; ex_reg_write = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall mem_alu_out", mem_alu_out, 32'h1234);
      chk("stall mem_mem_write", 32'(mem_mem_write), 32'h1);
      chk("stall ex_ready", 32'(ex_ready), 32'h0);
    end
    flush = 1;
    tick();
    chk("stall+flush mem_valid", 32'(mem_valid), 32'h0);

    // flush beats a trap-eligible instruction
    trap_instr(32'h0040_0020);
    flush = 1;
    tick();
    chk("flush trap exc_req", 32'(exc_req), 32'h0);
    chk("flush trap trap_cnt", 32'(trap_cnt), 32'h1);

    // saturation: five trap/ack sequences from a count of 1
    for (int i = 0; i < 5; i++) begin
      trap_instr(32'h0040_1000 + 32'(i * 4));
      tick();
      idle();
      exc_ack = 1;
      tick();
    end
    chk("sat trap_cnt", 32'(trap_cnt), 32'(MAX));

    // reset while trapped
    trap_instr(32'h0040_2000);
    tick();
    idle();
    chk("pre-rst exc_req", 32'(exc_req), 32'h1);
    rst = 1;
    tick();
    chk("rst-in-trap exc_req", 32'(exc_req), 32'h0);
    chk("rst-in-trap trap_cnt", 32'(trap_cnt), 32'h0);
    chk("rst-in-trap ex_ready", 32'(ex_ready), 32'h1);
    rst = 0;

    // mixed traffic checked by the model only
    for (int i = 0; i < 60; i++) begin
      ex_valid      = ($urandom % 4) != 0;
      ex_pc         = $urandom;
      ex_alu_out    = $urandom;
      ex_zero       = $urandom % 2;
      ex_great      = $urandom % 2;
      ex_overflow   = ($urandom % 3) == 0;
      ex_trap_en    = $urandom % 2;
      ex_store_data = $urandom;
      ex_dst        = 5'($urandom);
      ex_reg_write  = $urandom % 2;
      ex_mem_read   = $urandom % 2;
      ex_mem_write  = $urandom % 2;
      stall         = ($urandom % 5) == 0;
      flush         = ($urandom % 7) == 0;
      exc_ack       = ($urandom % 3) == 0;
      tick();
    end
    idle();
    tick();

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
